// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone RAM-port arbiter: FSM states, owner encoding, grant helpers.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  // 0 = M0, 1 = M1
  typedef logic owner_t;

  localparam owner_t     OWNER_M0   = 1'b0;
  localparam owner_t     OWNER_M1   = 1'b1;
  localparam logic [1:0] GRANT_NONE = 2'b00;

  function automatic logic [1:0] owner_onehot(input owner_t o);
    return (o == OWNER_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the master that did not own the port last wins.
module wb_rr_pick2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output owner_t     winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = OWNER_M0;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = OWNER_M1;
    end
  end

endmodule

// File: rtl/wb_ram_port_arbiter.sv
// Shares one RAM Wishbone port between M0/M1 (round-robin, grant held for the whole cyc), generating ack and registered read data.
// Define WB_ARB_TIMEOUT_EN to evict an owner idling in HOLD for TIMEOUT_CYCLES cycles (adds m0_err_o/m1_err_o).
module wb_ram_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int BUS_WIDTH      = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m0_we_i,
  input  logic [BE_WIDTH-1:0]   m0_sel_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_cyc_i,
  output logic                  m0_ack_o,
  input  logic [BUS_WIDTH-1:0]  m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_sel_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_cyc_i,
  output logic                  m1_ack_o,
  output logic [BUS_WIDTH-1:0]  ram_adr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  ram_we_o,
  output logic [BE_WIDTH-1:0]   ram_sel_o,
  output logic                  ram_stb_o,
  output logic                  ram_cyc_o,
`ifdef WB_ARB_TIMEOUT_EN
  output logic                  m0_err_o,
  output logic                  m1_err_o,
`endif
  output logic [1:0]            grant_o
);

  if (BE_WIDTH != DATA_WIDTH / 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_ram_port_arbiter: inconsistent parameters");
  end

  arb_state_t state, state_nxt;
  owner_t     owner, owner_nxt;
  owner_t     last_owner, last_owner_nxt;
  logic [1:0] grant_nxt;
  logic       ack;

  logic [1:0] req;
  owner_t     pick_winner;
  logic       pick_valid;

  logic                  own_cyc, own_stb, own_we;
  logic [BUS_WIDTH-1:0]  own_adr;
  logic [DATA_WIDTH-1:0] own_data;
  logic [BE_WIDTH-1:0]   own_sel;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  wb_rr_pick2 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign own_cyc  = (owner == OWNER_M1) ? m1_cyc_i  : m0_cyc_i;
  assign own_stb  = (owner == OWNER_M1) ? m1_stb_i  : m0_stb_i;
  assign own_we   = (owner == OWNER_M1) ? m1_we_i   : m0_we_i;
  assign own_adr  = (owner == OWNER_M1) ? m1_adr_i  : m0_adr_i;
  assign own_data = (owner == OWNER_M1) ? m1_data_i : m0_data_i;
  assign own_sel  = (owner == OWNER_M1) ? m1_sel_i  : m0_sel_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] hold_cnt;
  logic             evict;

  // Counts consecutive HOLD cycles in which the owner keeps cyc but issues no strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (state == HOLD && state_nxt == HOLD) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  assign m0_err_o = evict & (owner == OWNER_M0);
  assign m1_err_o = evict & (owner == OWNER_M1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWNER_M0;
      last_owner <= OWNER_M1;
      grant_o    <= GRANT_NONE;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      grant_o    <= grant_nxt;
    end
  end

  // RAM read port is combinational; the owner sees its data from the cycle after ACCESS onwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_data_o <= '0;
      m1_data_o <= '0;
    end else if (state == ACCESS) begin
      if (owner == OWNER_M1) begin
        m1_data_o <= ram_data_i;
      end else begin
        m0_data_o <= ram_data_i;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    grant_nxt      = grant_o;
    ack            = 1'b0;
    ram_adr_o      = '0;
    ram_data_o     = '0;
    ram_sel_o      = '0;
    ram_we_o       = 1'b0;
    ram_stb_o      = 1'b0;
    ram_cyc_o      = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    evict          = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick_winner;
          grant_nxt = owner_onehot(pick_winner);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ram_adr_o  = own_adr;
        ram_data_o = own_data;
        ram_sel_o  = own_sel;
        ram_we_o   = own_we;
        ram_stb_o  = 1'b1;
        ram_cyc_o  = 1'b1;
        state_nxt  = ACK;
      end
      ACK: begin
        ack       = 1'b1;
        ram_cyc_o = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        ram_cyc_o = 1'b1;
        if (!own_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          grant_nxt      = GRANT_NONE;
        end else if (own_stb) begin
          state_nxt = ACCESS;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          evict          = 1'b1;
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          grant_nxt      = GRANT_NONE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_ack_o = ack & (owner == OWNER_M0);
  assign m1_ack_o = ack & (owner == OWNER_M1);

endmodule

// File: tb/tb_wb_ram_port_arbiter.sv
// Bench for wb_ram_port_arbiter: transaction-level model with per-cycle compare plus directed literal checks.
module tb_wb_ram_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_wdat[2];
  logic          m_we  [2];
  logic [SW-1:0] m_sel [2];
  logic          m_stb [2];
  logic          m_cyc [2];

  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_wdat, ram_rdat;
  logic          ram_we, ram_stb, ram_cyc;
  logic [SW-1:0] ram_sel;
  logic [1:0]    grant;
`ifdef WB_ARB_TIMEOUT_EN
  logic          m0_err, m1_err;
`endif

  wb_ram_port_arbiter #(
    .BUS_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m_adr[0]), .m0_data_i(m_wdat[0]), .m0_data_o(m0_rdat), .m0_we_i(m_we[0]),
    .m0_sel_i(m_sel[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_ack_o(m0_ack),
    .m1_adr_i(m_adr[1]), .m1_data_i(m_wdat[1]), .m1_data_o(m1_rdat), .m1_we_i(m_we[1]),
    .m1_sel_i(m_sel[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_ack_o(m1_ack),
    .ram_adr_o(ram_adr), .ram_data_o(ram_wdat), .ram_data_i(ram_rdat), .ram_we_o(ram_we),
    .ram_sel_o(ram_sel), .ram_stb_o(ram_stb), .ram_cyc_o(ram_cyc),
`ifdef WB_ARB_TIMEOUT_EN
    .m0_err_o(m0_err), .m1_err_o(m1_err),
`endif
    .grant_o(grant)
  );

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Stand-in for the RAM port: combinational sel-gated read, byte-masked write on the edge.
  logic [31:0] ram_mem[32];
  assign ram_rdat = ram_mem[ram_adr] & bmask(ram_sel);
  always @(posedge clk)
    if (ram_cyc && ram_stb && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) ram_mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port, and in which cycle its access and ack fall.
  logic [31:0] sh_mem[32];
  int          cyc_n    = 0;
  int          mo       = -1;
  int          m_last   = 1;
  int          acc_at   = -100;
  int          ack_at   = -100;
  int          hold_cnt = 0;
  logic [31:0] exp_rd[2];
  logic        r0, r1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mo = -1; m_last = 1; acc_at = -100; ack_at = -100; hold_cnt = 0;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else begin
      if (mo < 0) begin
        r0 = m_cyc[0] && m_stb[0];
        r1 = m_cyc[1] && m_stb[1];
        if (r0 && r1) mo = 1 - m_last;
        else if (r0) mo = 0;
        else if (r1) mo = 1;
        if (mo >= 0) acc_at = cyc_n + 1;
      end else if (cyc_n == acc_at) begin
        exp_rd[mo] = sh_mem[m_adr[mo]] & bmask(m_sel[mo]);
        if (m_we[mo])
          sh_mem[m_adr[mo]] = (sh_mem[m_adr[mo]] & ~bmask(m_sel[mo])) | (m_wdat[mo] & bmask(m_sel[mo]));
        ack_at = cyc_n + 1;
      end else if (cyc_n == ack_at) begin
        hold_cnt = 0;
      end else begin
        if (!m_cyc[mo]) begin
          m_last = mo; mo = -1;
        end else if (m_stb[mo]) begin
          acc_at = cyc_n + 1;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (hold_cnt == TO - 1) begin
          m_last = mo; mo = -1;
        end else begin
          hold_cnt++;
`endif
        end
      end
      cyc_n++;
    end
  end

  logic       run_chk = 1'b0;
  logic       in_acc, in_ack, holding;
  logic [1:0] eg;

  always @(negedge clk) begin
    if (run_chk) begin
      in_acc  = (mo >= 0) && (cyc_n == acc_at);
      in_ack  = (mo >= 0) && (cyc_n == ack_at);
      holding = (mo >= 0) && !in_acc && !in_ack;
      eg      = (mo < 0) ? 2'b00 : ((mo == 0) ? 2'b01 : 2'b10);
      chk("grant", 64'(grant), 64'(eg));
      chk("m0_ack", 64'(m0_ack), 64'(in_ack && mo == 0));
      chk("m1_ack", 64'(m1_ack), 64'(in_ack && mo == 1));
      chk("m0_data", 64'(m0_rdat), 64'(exp_rd[0]));
      chk("m1_data", 64'(m1_rdat), 64'(exp_rd[1]));
      chk("ram_cyc", 64'(ram_cyc), 64'(mo >= 0));
      chk("ram_stb", 64'(ram_stb), 64'(in_acc));
      chk("ram_we", 64'(ram_we), 64'(in_acc && m_we[mo]));
      if (in_acc) begin
        chk("ram_adr", 64'(ram_adr), 64'(m_adr[mo]));
        chk("ram_sel", 64'(ram_sel), 64'(m_sel[mo]));
        chk("ram_wdat", 64'(ram_wdat), 64'(m_wdat[mo]));
      end
`ifdef WB_ARB_TIMEOUT_EN
      chk("m0_err", 64'(m0_err), 64'(holding && mo == 0 && m_cyc[0] && !m_stb[0] && hold_cnt == TO - 1));
      chk("m1_err", 64'(m1_err), 64'(holding && mo == 1 && m_cyc[1] && !m_stb[1] && hold_cnt == TO - 1));
`endif
    end
  end

  int we_hi = 0;
  always @(negedge clk) if (ram_we) we_hi++;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic xfer(input int k, input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                      input logic [DW-1:0] dat, input logic keep, output int lat, output logic [DW-1:0] rd);
    logic got;
    m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
    m_adr[k] = adr;  m_sel[k] = sel;  m_wdat[k] = dat;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #2;
      lat++;
      got = (k == 1) ? m1_ack : m0_ack;
    end
    chk("ack_seen", 64'(got), 64'(1));
    rd = (k == 1) ? m1_rdat : m0_rdat;
    m_stb[k] = 1'b0; m_we[k] = 1'b0;
    if (!keep) m_cyc[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int          l0, l1, l2;
  logic [31:0] rd0, rd1;
  int          c;
  logic        seen;

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram_mem[i] = 32'hA5A50000 | i;
      sh_mem[i]  = 32'hA5A50000 | i;
    end
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
      m_adr[k] = '0; m_sel[k] = '0; m_wdat[k] = '0;
    end
    step(3);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_ram_cyc", 64'(ram_cyc), 64'(0));
    chk("rst_m0_data", 64'(m0_rdat), 64'(0));
    run_chk = 1'b1;
    reset = 1'b1;
    step(1);

    // Write then read back through M0
    we_hi = 0;
    xfer(0, 1'b1, 5'd3, 4'hF, 32'hDEADBEEF, 1'b0, l0, rd0);
    chk("t1_wr_lat", 64'(l0), 64'(2));
    chk("t1_we_cycles", 64'(we_hi), 64'(1));
    step(2);
    xfer(0, 1'b0, 5'd3, 4'hF, 32'h0, 1'b0, l0, rd0);
    chk("t1_rd_lat", 64'(l0), 64'(2));
    chk("t1_rd_data", 64'(rd0), 64'(32'hDEADBEEF));
    step(2);

    // Byte-select write by M1
    xfer(1, 1'b1, 5'd7, 4'hF, 32'h0, 1'b0, l0, rd0);
    step(2);
    xfer(1, 1'b1, 5'd7, 4'b0101, 32'h11223344, 1'b0, l0, rd0);
    step(2);
    xfer(1, 1'b0, 5'd7, 4'hF, 32'h0, 1'b0, l0, rd0);
    chk("t3_rd_data", 64'(rd0), 64'(32'h00220044));
    step(2);

    // Simultaneous requests right after reset: M0 first, then M1
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    fork
      xfer(0, 1'b0, 5'd3, 4'hF, 32'h0, 1'b0, l0, rd0);
      xfer(1, 1'b0, 5'd7, 4'hF, 32'h0, 1'b0, l1, rd1);
      begin step(1); chk("t2_first_grant", 64'(grant), 64'(2'b01)); end
    join
    chk("t2_m0_lat", 64'(l0), 64'(2));
    chk("t2_m1_lat", 64'(l1), 64'(6));
    chk("t2_m0_data", 64'(rd0), 64'(32'hDEADBEEF));
    chk("t2_m1_data", 64'(rd1), 64'(32'h00220044));
    step(2);

    // M0 keeps cyc for three strobes; M1 waits for the whole bus cycle
    fork
      begin
        xfer(0, 1'b1, 5'd10, 4'hF, 32'hA1A1A1A1, 1'b1, l0, rd0);
        chk("t4_lat_a", 64'(l0), 64'(2));
        xfer(0, 1'b1, 5'd11, 4'hF, 32'hA2A2A2A2, 1'b1, l0, rd0);
        chk("t4_lat_b", 64'(l0), 64'(3));
        xfer(0, 1'b1, 5'd12, 4'hF, 32'hA3A3A3A3, 1'b0, l0, rd0);
        chk("t4_lat_c", 64'(l0), 64'(3));
      end
      begin
        step(1);
        xfer(1, 1'b0, 5'd10, 4'hF, 32'h0, 1'b0, l2, rd1);
      end
    join
    chk("t4_m1_lat", 64'(l2), 64'(11));
    chk("t4_m1_data", 64'(rd1), 64'(32'hA1A1A1A1));
    step(2);

    // Reset lands in the middle of an ACCESS write
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = 5'd9; m_sel[1] = 4'hF; m_wdat[1] = 32'h55AA55AA;
    step(1);
    chk("t5_we_before", 64'(ram_we), 64'(1));
    chk("t5_grant_before", 64'(grant), 64'(2'b10));
    #1 reset = 1'b0;
    #1;
    chk("t5_we_abort", 64'(ram_we), 64'(0));
    chk("t5_grant_abort", 64'(grant), 64'(0));
    chk("t5_no_ack", 64'(m1_ack), 64'(0));
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    xfer(0, 1'b0, 5'd9, 4'hF, 32'h0, 1'b0, l0, rd0);
    chk("t5_lat_after", 64'(l0), 64'(2));
    chk("t5_mem_kept", 64'(rd0), 64'(32'hA5A50009));
    step(2);

`ifdef WB_ARB_TIMEOUT_EN
    // M0 idles in HOLD with cyc high while M1 waits
    xfer(0, 1'b0, 5'd3, 4'hF, 32'h0, 1'b1, l0, rd0);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 5'd3; m_sel[1] = 4'hF;
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin step(1); c++; seen = m0_err; end
    chk("to_cycles", 64'(c), 64'(16));
    step(1);
    chk("to_idle_grant", 64'(grant), 64'(0));
    step(1);
    chk("to_m1_grant", 64'(grant), 64'(2'b10));
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin step(1); c++; seen = m1_ack; end
    chk("to_m1_ack", 64'(seen), 64'(1));
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cyc[0] = 1'b0;
    step(3);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
